// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
//  req_id_e  : which requester owns a memory access (instruction fetch or data).
//  rsp_tag_t : per-access tag carried alongside the memory read latency so the
//              returning word can be steered to the right response port.
package mem_arb_pkg;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    v;   // slot holds a live access
    req_id_e id;  // owner of the access
    logic    wr;  // access was a write (ack carries no data)
  } rsp_tag_t;

  localparam rsp_tag_t TAG_IDLE = '{v: 1'b0, id: REQ_IF, wr: 1'b0};

endpackage

// File: rtl/inst_data_mem_arbiter_if.sv
// Bundle of every request, response and memory-side signal of the arbiter.
//  slave  : the arbiter's view (takes requests and read data, drives grants,
//           responses and the memory command).
//  master : the surroundings' view (core pipeline plus memory).
interface inst_data_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // instruction fetch side
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  // data load/store side
  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  // single-port memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    input  d_req_valid, d_addr, d_we, d_wdata, d_be,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req_valid, if_addr,
    output d_req_valid, d_addr, d_we, d_wdata, d_be,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/arb_rsp_pipe.sv
// Fixed-depth delay line of response tags, matching the memory read latency.
//  clk      : clock, rising edge
//  rst_n    : asynchronous active-low clear (drops every in-flight tag)
//  push_tag : tag of the access granted this cycle (v=0 when idle)
//  pop_tag  : tag of the access granted DEPTH cycles ago
module arb_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t push_tag,
  output rsp_tag_t pop_tag
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    rsp_tag_t tag_d;
    rsp_tag_t tag_q;

    if (gi == 0) begin : g_head
      assign tag_d = push_tag;
    end else begin : g_body
      assign tag_d = g_stage[gi-1].tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_q <= TAG_IDLE;
      end else begin
        tag_q <= tag_d;
      end
    end
  end

  assign pop_tag = g_stage[DEPTH-1].tag_q;

endmodule

// File: rtl/inst_data_mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch
// and data load/store. One access is granted per cycle; data normally wins,
// but a fetch that has been refused STARVE_MAX cycles in a row is forced
// through. Read data comes back MEM_LAT cycles after the grant and is steered
// by a tag pipeline to the owner's response port; writes get a data-less ack.
//  clk, rst_n : clock (rising edge), asynchronous active-low reset
//  bus        : request/response handshakes for both requesters and the
//               memory command/read-data port (see inst_data_mem_arbiter_if)
module inst_data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  inst_data_mem_arbiter_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t              starve_cnt_q;
  cnt_t              starve_cnt_d;
  logic              starved;
  logic              if_gnt;
  logic              d_gnt;

  logic              drv_en;
  logic              drv_we;
  logic [ADDR_W-1:0] drv_addr;
  logic [DATA_W-1:0] drv_wdata;
  logic [BE_W-1:0]   drv_be;

  rsp_tag_t          push_tag;
  rsp_tag_t          pop_tag;

  // Grants are qualified by rst_n so that no ready or memory strobe can
  // escape while the block is held in reset, even if requesters keep valid.
  always_comb begin
    starved = (starve_cnt_q == cnt_t'(STARVE_MAX));
    if_gnt  = rst_n & bus.if_req_valid & (~bus.d_req_valid | starved);
    d_gnt   = rst_n & bus.d_req_valid & ~if_gnt;
  end

  // Counts consecutive cycles a waiting fetch was refused; saturates so the
  // forced-win condition stays asserted until the fetch actually goes.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req_valid || if_gnt) begin
      starve_cnt_d = '0;
    end else if (!starved) begin
      starve_cnt_d = starve_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Memory command mux; unused fields are forced to 0 rather than passed
  // through so the RAM never sees stale write data on reads or idle cycles.
  always_comb begin
    drv_en    = 1'b0;
    drv_we    = 1'b0;
    drv_addr  = '0;
    drv_wdata = '0;
    drv_be    = '0;
    if (if_gnt) begin
      drv_en   = 1'b1;
      drv_addr = bus.if_addr;
    end else if (d_gnt) begin
      drv_en   = 1'b1;
      drv_we   = bus.d_we;
      drv_addr = bus.d_addr;
      if (bus.d_we) begin
        drv_wdata = bus.d_wdata;
        drv_be    = bus.d_be;
      end
    end
  end

  always_comb begin
    push_tag    = TAG_IDLE;
    push_tag.v  = if_gnt | d_gnt;
    push_tag.id = d_gnt ? REQ_D : REQ_IF;
    push_tag.wr = d_gnt & bus.d_we;
  end

  arb_rsp_pipe #(
    .DEPTH (MEM_LAT)
  ) u_rsp_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_tag (push_tag),
    .pop_tag  (pop_tag)
  );

  // Response steering: the tag leaving the pipe lines up with mem_rdata for
  // the same access, so the word is passed straight through to its owner.
  always_comb begin
    bus.if_rsp_valid = pop_tag.v & (pop_tag.id == REQ_IF);
    bus.d_rsp_valid  = pop_tag.v & (pop_tag.id == REQ_D);
    bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rdata : '0;
    bus.d_rsp_data   = (bus.d_rsp_valid && !pop_tag.wr) ? bus.mem_rdata : '0;
  end

  assign bus.if_req_ready = if_gnt;
  assign bus.d_req_ready  = d_gnt;
  assign bus.mem_en       = drv_en;
  assign bus.mem_we       = drv_we;
  assign bus.mem_addr     = drv_addr;
  assign bus.mem_wdata    = drv_wdata;
  assign bus.mem_be       = drv_be;

endmodule

// File: tb/tb_inst_data_mem_arbiter.sv
// Self-checking bench: two arbiters (MEM_LAT=1 and MEM_LAT=3) driven by the
// same request stream, each attached to its own behavioural RAM. Expected
// grants, memory commands and responses come from a cycle-level model of
// the arbitration rules plus a shadow copy of the memory contents.
module tb_inst_data_mem_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int SMAX  = 4;
  localparam int CMAX  = 4096;
  localparam int NRAND = 600;
  localparam int WORDS = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared request stimulus
  logic          if_v   = 1'b0;
  logic [AW-1:0] if_a   = '0;
  logic          d_v    = 1'b0;
  logic [AW-1:0] d_a    = '0;
  logic          d_we_s = 1'b0;
  logic [DW-1:0] d_wd   = '0;
  logic [BW-1:0] d_be_s = '0;

  inst_data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  inst_data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  assign bus1.if_req_valid = if_v;
  assign bus1.if_addr      = if_a;
  assign bus1.d_req_valid  = d_v;
  assign bus1.d_addr       = d_a;
  assign bus1.d_we         = d_we_s;
  assign bus1.d_wdata      = d_wd;
  assign bus1.d_be         = d_be_s;
  assign bus3.if_req_valid = if_v;
  assign bus3.if_addr      = if_a;
  assign bus3.d_req_valid  = d_v;
  assign bus3.d_addr       = d_a;
  assign bus3.d_we         = d_we_s;
  assign bus3.d_wdata      = d_wd;
  assign bus3.d_be         = d_be_s;

  inst_data_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  inst_data_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)
  ) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return (32'h9E37_79B9 * 32'(i)) ^ 32'h1234_5678;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] w;
    w = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  // behavioural RAMs, read data delayed to each instance's latency
  logic [DW-1:0] ram1 [WORDS];
  logic [DW-1:0] ram3 [WORDS];
  logic [DW-1:0] rd1_q    = '0;
  logic [DW-1:0] rd3_q [3];
  logic          ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < WORDS; i++) begin
        ram1[i] <= pat(i);
        ram3[i] <= pat(i);
      end
      rd1_q    <= '0;
      rd3_q[0] <= '0;
      rd3_q[1] <= '0;
      rd3_q[2] <= '0;
      ram_init <= 1'b1;
    end else begin
      if (bus1.mem_en && bus1.mem_we)
        ram1[bus1.mem_addr] <= merge(ram1[bus1.mem_addr], bus1.mem_wdata, bus1.mem_be);
      rd1_q <= (bus1.mem_en && !bus1.mem_we) ? ram1[bus1.mem_addr] : '0;
      if (bus3.mem_en && bus3.mem_we)
        ram3[bus3.mem_addr] <= merge(ram3[bus3.mem_addr], bus3.mem_wdata, bus3.mem_be);
      rd3_q[0] <= (bus3.mem_en && !bus3.mem_we) ? ram3[bus3.mem_addr] : '0;
      rd3_q[1] <= rd3_q[0];
      rd3_q[2] <= rd3_q[1];
    end
  end

  assign bus1.mem_rdata = rd1_q;
  assign bus3.mem_rdata = rd3_q[2];

  // reference model state
  logic [DW-1:0] shadow [WORDS];
  bit            exp_ifv [2][CMAX];
  bit            exp_dv  [2][CMAX];
  logic [DW-1:0] exp_dat [2][CMAX];
  int            cyc    = 0;
  int            denied = 0;
  bit            g_if   = 1'b0;
  bit            g_d    = 1'b0;
  int            total  = 0;
  int            bad    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_inst(input int k,
                            input logic ifr, input logic dr,
                            input logic men, input logic mwe,
                            input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                            input logic [BW-1:0] mbe,
                            input logic ifrv, input logic [DW-1:0] ifrd,
                            input logic drv, input logic [DW-1:0] drd);
    string         p;
    bit            wr_g;
    logic [AW-1:0] e_addr;
    p      = (k == 0) ? "lat1" : "lat3";
    wr_g   = g_d && d_we_s;
    e_addr = g_if ? if_a : (g_d ? d_a : '0);
    chk({p, ".if_req_ready"}, 64'(ifr), 64'(g_if));
    chk({p, ".d_req_ready"},  64'(dr),  64'(g_d));
    chk({p, ".mem_en"},       64'(men), 64'(g_if || g_d));
    chk({p, ".mem_we"},       64'(mwe), 64'(wr_g));
    chk({p, ".mem_addr"},     64'(ma),  64'(e_addr));
    chk({p, ".mem_wdata"},    64'(mwd), wr_g ? 64'(d_wd) : 64'd0);
    chk({p, ".mem_be"},       64'(mbe), wr_g ? 64'(d_be_s) : 64'd0);
    chk({p, ".if_rsp_valid"}, 64'(ifrv), 64'(exp_ifv[k][cyc]));
    chk({p, ".if_rsp_data"},  64'(ifrd), exp_ifv[k][cyc] ? 64'(exp_dat[k][cyc]) : 64'd0);
    chk({p, ".d_rsp_valid"},  64'(drv),  64'(exp_dv[k][cyc]));
    chk({p, ".d_rsp_data"},   64'(drd),  exp_dv[k][cyc] ? 64'(exp_dat[k][cyc]) : 64'd0);
  endtask

  // Evaluate the current cycle: predict the grant, compare both instances,
  // and (when commit is set) schedule responses and update the shadow RAM.
  task automatic eval(input bit commit);
    int due;
    g_if = rst_n && if_v && (!d_v || denied == SMAX);
    g_d  = rst_n && d_v && !g_if;
    check_inst(0, bus1.if_req_ready, bus1.d_req_ready, bus1.mem_en, bus1.mem_we,
               bus1.mem_addr, bus1.mem_wdata, bus1.mem_be,
               bus1.if_rsp_valid, bus1.if_rsp_data, bus1.d_rsp_valid, bus1.d_rsp_data);
    check_inst(1, bus3.if_req_ready, bus3.d_req_ready, bus3.mem_en, bus3.mem_we,
               bus3.mem_addr, bus3.mem_wdata, bus3.mem_be,
               bus3.if_rsp_valid, bus3.if_rsp_data, bus3.d_rsp_valid, bus3.d_rsp_data);
    if (commit) begin
      for (int k = 0; k < 2; k++) begin
        due = cyc + ((k == 0) ? 1 : 3);
        if (due < CMAX) begin
          if (g_if) begin
            exp_ifv[k][due] = 1'b1;
            exp_dat[k][due] = shadow[if_a];
          end else if (g_d) begin
            exp_dv[k][due]  = 1'b1;
            exp_dat[k][due] = d_we_s ? '0 : shadow[d_a];
          end
        end
      end
      if (g_d && d_we_s) shadow[d_a] = merge(shadow[d_a], d_wd, d_be_s);
      if (!rst_n || !if_v || g_if) denied = 0;
      else if (denied < SMAX) denied++;
    end
  endtask

  task automatic step(input logic iv, input logic [AW-1:0] ia,
                      input logic dv, input logic [AW-1:0] da, input logic dwe,
                      input logic [DW-1:0] dwd, input logic [BW-1:0] dbe);
    @(posedge clk);
    #1;
    if_v = iv; if_a = ia;
    d_v = dv; d_a = da; d_we_s = dwe; d_wd = dwd; d_be_s = dbe;
    @(negedge clk);
    cyc++;
    eval(1'b1);
    $display("cyc=%0d rst_n=%0b if_v=%0b if_a=%03h d_v=%0b d_we=%0b d_a=%03h gnt_if=%0b gnt_d=%0b",
             cyc, rst_n, iv, ia, dv, dwe, da, g_if, g_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    logic          p_if;
    logic [AW-1:0] p_ia;
    logic          p_d;
    logic [AW-1:0] p_da;
    logic          p_we;
    logic [DW-1:0] p_wd;
    logic [BW-1:0] p_be;

    for (int i = 0; i < WORDS; i++) shadow[i] = pat(i);

    // reset state, with both requesters asserting valid
    step(1'b1, 10'h055, 1'b1, 10'h066, 1'b1, 32'hFFFF_FFFF, 4'hF);
    idle(2);
    rst_n = 1'b1;

    // idle: nothing granted, nothing returned
    idle(3);

    // single fetch read
    step(1'b1, 10'h010, 1'b0, '0, 1'b0, '0, '0);
    idle(3);

    // data write to the top word, then read it back
    step(1'b0, '0, 1'b1, 10'h3FF, 1'b1, 32'hDEAD_BEEF, 4'b0101);
    idle(3);
    step(1'b0, '0, 1'b1, 10'h3FF, 1'b0, '0, '0);
    idle(3);

    // both valid every cycle: D,D,D,D,IF repeating
    p_ia = 10'h100;
    for (int k = 0; k < 15; k++) begin
      step(1'b1, p_ia, 1'b1, 10'(k), 1'b0, '0, '0);
      chk("starve.if_wins", 64'(bus1.if_req_ready), 64'((k % 5) == 4));
      chk("starve.d_wins",  64'(bus1.d_req_ready),  64'((k % 5) != 4));
      if (g_if) p_ia = p_ia + 10'd1;
    end
    idle(4);

    // alternating single fetch / data reads
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) step(1'b1, 10'(k * 7), 1'b0, '0, 1'b0, '0, '0);
      else            step(1'b0, '0, 1'b1, 10'(k * 5 + 1), 1'b0, '0, '0);
    end
    idle(4);

    // random traffic, each requester holding its request until granted
    p_if = 1'b0; p_d = 1'b0;
    p_ia = '0; p_da = '0; p_we = 1'b0; p_wd = '0; p_be = '0;
    for (int n = 0; n < NRAND; n++) begin
      if (!p_if && ($urandom_range(0, 2) != 0)) begin
        p_if = 1'b1;
        p_ia = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
      end
      if (!p_d && ($urandom_range(0, 2) != 0)) begin
        p_d  = 1'b1;
        p_da = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
        p_we = 1'($urandom_range(0, 1));
        p_wd = 32'($urandom);
        p_be = 4'($urandom);
      end
      step(p_if, p_ia, p_d, p_da, p_we, p_wd, p_be);
      if (g_if) p_if = 1'b0;
      if (g_d)  p_d  = 1'b0;
    end
    idle(4);

    // reset with two reads in flight
    step(1'b1, 10'h020, 1'b0, '0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 10'h021, 1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int j = cyc; j < CMAX; j++) begin
      exp_ifv[0][j] = 1'b0; exp_ifv[1][j] = 1'b0;
      exp_dv[0][j]  = 1'b0; exp_dv[1][j]  = 1'b0;
    end
    denied = 0;
    eval(1'b0);
    $display("cyc=%0d async reset asserted with reads in flight", cyc);
    idle(2);
    rst_n = 1'b1;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
